// File: rtl/cmd_sequencer.sv
// Keypad command sequencer: queues key codes in a FIFO and issues them to a calculator with a ready/busy handshake.
// Optional build macro CMD_SEQ_FILTER_EN drops incoming codes equal to NOP_CODE.
module cmd_sequencer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [3:0]  NOP_CODE = 4'hD,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     key_valid,
  input  logic [3:0]               key_code,
  input  logic [1:0]               calc_status,
  output logic [3:0]               cmd,
  output logic                     key_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     busy,
  output logic                     err,
  output logic                     overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] STAT_ERROR = 2'b00;
  localparam logic [1:0] STAT_BUSY  = 2'b01;
  localparam logic [1:0] STAT_READY = 2'b10;

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_READY, ERROR} state_t;

  state_t        state;
  state_t        state_next;
  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_next;
  logic [3:0]    cmd_next;
  logic          pop;
  logic          push;
  logic          push_req;
  logic          drop;
  logic          flush;
  logic          timed_out;
  logic          filtered;

`ifdef CMD_SEQ_FILTER_EN
  assign filtered = (key_code == NOP_CODE);
`else
  assign filtered = 1'b0;
`endif

  assign key_ready  = (count < CW'(DEPTH));
  assign fifo_count = count;
  assign busy       = (state == WAIT_BUSY) || (state == WAIT_READY);
  assign err        = (state == ERROR);

  // Pushes are ignored in ERROR; a full FIFO drops the code and flags overflow.
  assign push_req  = key_valid && !filtered && (state != ERROR);
  assign push      = push_req && key_ready;
  assign drop      = push_req && !key_ready;
  assign flush     = (state_next == ERROR);
  assign timed_out = (timer == TW'(TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state, issued command, timer and pop decision; calc error status overrides all.
  always_comb begin
    state_next = state;
    cmd_next   = cmd;
    timer_next = timer;
    pop        = 1'b0;
    if (calc_status == STAT_ERROR) begin
      state_next = ERROR;
      cmd_next   = NOP_CODE;
    end else begin
      case (state)
        IDLE: begin
          if ((count != '0) && (calc_status == STAT_READY)) begin
            pop        = 1'b1;
            cmd_next   = mem[rd_ptr];
            timer_next = '0;
            state_next = WAIT_BUSY;
          end else begin
            cmd_next = NOP_CODE;
          end
        end
        WAIT_BUSY: begin
          if (calc_status == STAT_BUSY) begin
            cmd_next   = NOP_CODE;
            timer_next = '0;
            state_next = WAIT_READY;
          end else if (timed_out) begin
            cmd_next   = NOP_CODE;
            state_next = ERROR;
          end else begin
            timer_next = timer + TW'(1);
          end
        end
        WAIT_READY: begin
          cmd_next = NOP_CODE;
          if (calc_status == STAT_READY) begin
            state_next = IDLE;
          end else if (timed_out) begin
            state_next = ERROR;
          end else begin
            timer_next = timer + TW'(1);
          end
        end
        ERROR: begin
          cmd_next = NOP_CODE;
        end
        default: begin
          cmd_next   = NOP_CODE;
          state_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cmd      <= NOP_CODE;
      timer    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      cmd   <= cmd_next;
      timer <= timer_next;
      if (drop) begin
        overflow <= 1'b1;
      end
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // Storage needs no reset; validity is tracked by count and pointers.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= key_code;
    end
  end

endmodule

// File: tb/tb_cmd_sequencer.sv
// Self-checking bench for cmd_sequencer: queue-based reference model compared every cycle plus directed literal checks.
module tb_cmd_sequencer;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 16;
  localparam logic [3:0]  NOP     = 4'hD;

  localparam int P_IDLE   = 0;
  localparam int P_ISSUED = 1;
  localparam int P_ACKED  = 2;
  localparam int P_FAIL   = 3;

  logic       clock;
  logic       reset;
  logic       key_valid;
  logic [3:0] key_code;
  logic [1:0] calc_status;
  logic [3:0] cmd;
  logic       key_ready;
  logic [2:0] fifo_count;
  logic       busy;
  logic       err;
  logic       overflow;

  int tests = 0;
  int fails = 0;

  cmd_sequencer #(.DEPTH(DEPTH), .NOP_CODE(NOP), .TIMEOUT(TIMEOUT)) dut (
    .clock       (clock),
    .reset       (reset),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .calc_status (calc_status),
    .cmd         (cmd),
    .key_ready   (key_ready),
    .fifo_count  (fifo_count),
    .busy        (busy),
    .err         (err),
    .overflow    (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: a queue of pending codes plus the handshake phase of the code in flight.
  logic [3:0] mq [$];
  logic [3:0] m_cmd = NOP;
  int         ph = P_IDLE;
  int         wt = 0;
  bit         m_ovf = 1'b0;
  bit         started = 1'b0;

  always @(posedge clock) begin : model_blk
    bit acc;
    bit filt;
    if (reset) begin
      mq.delete();
      ph      = P_IDLE;
      m_cmd   = NOP;
      wt      = 0;
      m_ovf   = 1'b0;
      started = 1'b1;
    end else begin
      filt = 1'b0;
`ifdef CMD_SEQ_FILTER_EN
      filt = (key_code == NOP);
`endif
      acc = key_valid && !filt && (ph != P_FAIL) && (mq.size() < DEPTH);
      if (key_valid && !filt && (ph != P_FAIL) && (mq.size() == DEPTH)) m_ovf = 1'b1;
      if (ph == P_FAIL) begin
        acc = 1'b0;
      end else if (calc_status == 2'b00) begin
        ph = P_FAIL;
      end else if (ph == P_IDLE) begin
        if (mq.size() > 0 && calc_status == 2'b10) begin
          m_cmd = mq.pop_front();
          ph    = P_ISSUED;
          wt    = 0;
        end
      end else if (ph == P_ISSUED) begin
        if (calc_status == 2'b01) begin
          m_cmd = NOP;
          ph    = P_ACKED;
          wt    = 0;
        end else begin
          wt++;
          if (wt == TIMEOUT) ph = P_FAIL;
        end
      end else begin
        if (calc_status == 2'b10) begin
          ph = P_IDLE;
        end else begin
          wt++;
          if (wt == TIMEOUT) ph = P_FAIL;
        end
      end
      if (ph == P_FAIL) begin
        mq.delete();
        m_cmd = NOP;
        acc   = 1'b0;
      end
      if (acc) mq.push_back(key_code);
    end
  end

  function automatic bit fld(input string n, input int act, input int exp);
    if (act != exp) begin
      $display("FAIL cycle-%s at %0t: got %0d expected %0d", n, $time, act, exp);
      return 1'b1;
    end
    return 1'b0;
  endfunction

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin : cmp_blk
    bit bad;
    if (started) begin
      tests++;
      bad = fld("cmd", int'(cmd), int'(m_cmd))
          | fld("fifo_count", int'(fifo_count), mq.size())
          | fld("key_ready", int'(key_ready), int'(mq.size() < DEPTH))
          | fld("busy", int'(busy), int'(ph == P_ISSUED || ph == P_ACKED))
          | fld("err", int'(err), int'(ph == P_FAIL))
          | fld("overflow", int'(overflow), int'(m_ovf));
      if (bad) fails++;
    end
  end

  // Record each issued code at the cycle the handshake starts (busy rising).
  logic [3:0] obs [$];
  bit         prev_busy = 1'b0;
  always @(negedge clock) begin
    if (busy === 1'b1 && !prev_busy) obs.push_back(cmd);
    prev_busy = (busy === 1'b1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] c);
    key_valid = 1'b1;
    key_code  = c;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    obs.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cmd"}, int'(cmd), int'(NOP));
    check({tag, "_fifo_count"}, int'(fifo_count), 0);
    check({tag, "_key_ready"}, int'(key_ready), 1);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_err"}, int'(err), 0);
    check({tag, "_overflow"}, int'(overflow), 0);
  endtask

  // Calculator stand-in: for each issue, go busy for 8 cycles, then ready again.
  task automatic run_calc(input int total, input int first);
    int guard;
    calc_status = 2'b10;
    for (int i = first; i < total; i++) begin
      guard = 0;
      while (obs.size() < i + 1 && guard < 60) begin
        tick();
        guard++;
      end
      if (obs.size() < i + 1) begin
        tests++;
        fails++;
        $display("FAIL calc_wait: issued %0d expected at least %0d", obs.size(), i + 1);
      end
      tick();
      calc_status = 2'b01;
      repeat (8) tick();
      calc_status = 2'b10;
    end
    repeat (3) tick();
  endtask

  initial begin
    reset       = 1'b1;
    key_valid   = 1'b0;
    key_code    = 4'h0;
    calc_status = 2'b10;
    tick();
    do_reset();
    check_reset_vals("reset");

    // Ordered issue of 3, A, 4, E with a full ready/busy/ready handshake each.
    push(4'h3); push(4'hA); push(4'h4); push(4'hE);
    run_calc(4, 0);
    check("seq_count", obs.size(), 4);
    if (obs.size() == 4) begin
      check("seq0", int'(obs[0]), 3);
      check("seq1", int'(obs[1]), 10);
      check("seq2", int'(obs[2]), 4);
      check("seq3", int'(obs[3]), 14);
    end
    check("seq_empty", int'(fifo_count), 0);

    // Overflow: five pushes with calculator busy.
    calc_status = 2'b01;
    do_reset();
    push(4'h1); push(4'h2); push(4'h3); push(4'h4);
    check("ovf_before", int'(overflow), 0);
    push(4'h5);
    check("ovf_count", int'(fifo_count), 4);
    check("ovf_flag", int'(overflow), 1);
    check("ovf_key_ready", int'(key_ready), 0);

    // Simultaneous push and pop at count 2, then drain across pointer wrap.
    calc_status = 2'b01;
    do_reset();
    push(4'h1); push(4'h2);
    calc_status = 2'b10;
    push(4'h3);
    check("pp_count", int'(fifo_count), 2);
    check("pp_cmd", int'(cmd), 1);
    calc_status = 2'b01;
    push(4'h4); push(4'h5);
    check("pp_count4", int'(fifo_count), 4);
    run_calc(5, 1);
    check("wrap_count", obs.size(), 5);
    if (obs.size() == 5) begin
      for (int i = 0; i < 5; i++) check("wrap_order", int'(obs[i]), i + 1);
    end

    // Timeout in WAIT_BUSY: ready held, never busy.
    calc_status = 2'b10;
    do_reset();
    push(4'h7);
    tick();
    check("latency_cmd", int'(cmd), 7);
    repeat (15) tick();
    check("tmo_not_yet", int'(err), 0);
    tick();
    check("tmo_err", int'(err), 1);
    check("tmo_count", int'(fifo_count), 0);
    check("tmo_cmd", int'(cmd), int'(NOP));
    push(4'h1);
    repeat (3) tick();
    check("err_sticky", int'(err), 1);
    check("err_push_count", int'(fifo_count), 0);
    check("err_push_ovf", int'(overflow), 0);

    // Status error during WAIT_READY with two queued, then reset.
    calc_status = 2'b10;
    do_reset();
    push(4'h1); push(4'h2); push(4'h3);
    calc_status = 2'b01;
    tick(); tick();
    check("werr_busy", int'(busy), 1);
    check("werr_queued", int'(fifo_count), 2);
    calc_status = 2'b00;
    tick();
    check("werr_err", int'(err), 1);
    check("werr_flush", int'(fifo_count), 0);
    calc_status = 2'b10;
    do_reset();
    check_reset_vals("after_err");

    // NOP_CODE as a key: filtered only when the macro is defined.
    calc_status = 2'b10;
    do_reset();
    push(NOP); push(4'h5);
`ifdef CMD_SEQ_FILTER_EN
    run_calc(1, 0);
    check("filt_n", obs.size(), 1);
    if (obs.size() == 1) check("filt0", int'(obs[0]), 5);
`else
    run_calc(2, 0);
    check("nofilt_n", obs.size(), 2);
    if (obs.size() == 2) begin
      check("nofilt0", int'(obs[0]), int'(NOP));
      check("nofilt1", int'(obs[1]), 5);
    end
`endif

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
